// File: rtl/icache_dm_ctrl_if.sv
// Bus bundle for the direct-mapped I-cache controller: CPU fetch port,
// cache storage array strobes/returns, and backing-memory request/ack.
// The controller is the slave side; the CPU/storage/memory environment is the master.
interface icache_dm_ctrl_if;
  // CPU fetch port
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic        cpu_ready;
  logic        cpu_valid;
  logic [31:0] cpu_rdata;
  logic        cpu_err;
  // cache storage array
  logic        st_read;
  logic        st_write;
  logic [31:0] st_address;
  logic [31:0] st_write_block;
  logic [31:0] st_read_data;
  logic        st_hit;
  // backing memory
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_addr, st_read_data, st_hit, mem_ack, mem_rdata,
    output cpu_ready, cpu_valid, cpu_rdata, cpu_err,
           st_read, st_write, st_address, st_write_block,
           mem_req, mem_addr
  );

  modport master (
    output cpu_req, cpu_addr, st_read_data, st_hit, mem_ack, mem_rdata,
    input  cpu_ready, cpu_valid, cpu_rdata, cpu_err,
           st_read, st_write, st_address, st_write_block,
           mem_req, mem_addr
  );
endinterface

// File: rtl/icache_dm_ctrl.sv
// Sequencing controller for a direct-mapped instruction cache. One fetch in
// flight: lookup in storage, on miss fetch from memory (with optional
// timeout), fill storage and return the word. Keeps saturating hit/miss counts.
module icache_dm_ctrl #(
  parameter int CNT_WIDTH   = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  icache_dm_ctrl_if.slave      bus,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_CHECK,
    S_MEM,
    S_FILL
  } state_t;

  // Timeout counter only needs to reach MEM_TIMEOUT-1; a zero setting disables it.
  localparam int              TMO_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam bit              TMO_EN   = (MEM_TIMEOUT > 0);
  localparam logic [TMO_W-1:0] TMO_LAST = (MEM_TIMEOUT > 0) ? TMO_W'(MEM_TIMEOUT - 1) : '0;

  state_t               state_q, state_d;
  logic [31:0]          addr_q, addr_d;
  logic [31:0]          fill_q, fill_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;
  logic [CNT_WIDTH-1:0] hit_q, hit_d;
  logic [CNT_WIDTH-1:0] miss_q, miss_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;

  // State register and all datapath/status registers, cleared by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      fill_q  <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      hit_q   <= '0;
      miss_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      fill_q  <= fill_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state and register-update decisions; response strobes default low.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    fill_d  = fill_q;
    rdata_d = rdata_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    hit_d   = hit_q;
    miss_d  = miss_q;
    tmo_d   = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cpu_req) begin
          addr_d  = bus.cpu_addr;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (bus.st_hit) begin
          rdata_d = bus.st_read_data;
          valid_d = 1'b1;
          if (hit_q != '1) hit_d = hit_q + 1'b1;
          state_d = S_IDLE;
        end else begin
          if (miss_q != '1) miss_d = miss_q + 1'b1;
          tmo_d   = '0;
          state_d = S_MEM;
        end
      end
      S_MEM: begin
        // An ack in the final timeout cycle still completes a normal fill.
        if (bus.mem_ack) begin
          fill_d  = bus.mem_rdata;
          state_d = S_FILL;
        end else if (TMO_EN && (tmo_q == TMO_LAST)) begin
          rdata_d = '0;
          valid_d = 1'b1;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_FILL: begin
        rdata_d = fill_q;
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Strobes decode from state alone; addresses and fill word always show latched values.
  assign bus.cpu_ready      = (state_q == S_IDLE);
  assign bus.st_read        = (state_q == S_LOOKUP);
  assign bus.mem_req        = (state_q == S_MEM);
  assign bus.st_write       = (state_q == S_FILL);
  assign bus.st_address     = addr_q;
  assign bus.mem_addr       = addr_q;
  assign bus.st_write_block = fill_q;
  assign bus.cpu_valid      = valid_q;
  assign bus.cpu_err        = err_q;
  assign bus.cpu_rdata      = rdata_q;
  assign hit_count          = hit_q;
  assign miss_count         = miss_q;

endmodule

// File: tb/tb_icache_dm_ctrl.sv
// Bench for icache_dm_ctrl: storage-array and memory models around the DUT,
// a reference predictor pushing expected responses, and a response monitor.
module tb_icache_dm_ctrl;
  localparam int CW  = 4;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [CW-1:0] hit_count, miss_count;

  icache_dm_ctrl_if bus();

  icache_dm_ctrl #(.CNT_WIDTH(CW), .MEM_TIMEOUT(TMO)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .hit_count (hit_count),
    .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'hDEAD_BEEF;
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Storage array model: registered hit/read_data, one word per block, index addr[11:2].
  logic        sv_v   [1024];
  logic [19:0] sv_tag [1024];
  logic [31:0] sv_data[1024];
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 1024; i++) sv_v[i] <= 1'b0;
      bus.st_hit       <= 1'b0;
      bus.st_read_data <= '0;
    end else begin
      if (bus.st_read) begin
        bus.st_hit       <= sv_v[bus.st_address[11:2]] && (sv_tag[bus.st_address[11:2]] == bus.st_address[31:12]);
        bus.st_read_data <= sv_data[bus.st_address[11:2]];
      end
      if (bus.st_write) begin
        sv_v[bus.st_address[11:2]]    <= 1'b1;
        sv_tag[bus.st_address[11:2]]  <= bus.st_address[31:12];
        sv_data[bus.st_address[11:2]] <= bus.st_write_block;
      end
    end
  end

  // Memory model: ack after mem_wait cycles of mem_req, or never when mem_on=0.
  int mem_wait = 0;
  bit mem_on   = 1'b1;
  int mcnt     = 0;
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        bus.mem_ack = 1'b0;
        mcnt = 0;
      end else if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
        mcnt = 0;
      end else if (bus.mem_req) begin
        if (mem_on && mcnt == mem_wait) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = mem_word(bus.mem_addr);
        end else begin
          mcnt++;
        end
      end else begin
        mcnt = 0;
      end
    end
  end

  // Scoreboard and reference cache state
  typedef struct {
    logic [31:0]   rdata;
    logic          err;
    int            lat;
    logic [CW-1:0] hits;
    logic [CW-1:0] misses;
    int            acc;
  } exp_t;
  exp_t        sb[$];
  bit          rv[1024];
  logic [19:0] rt[1024];
  int          exp_hits   = 0;
  int          exp_misses = 0;
  localparam int CMAX = (1 << CW) - 1;

  task automatic predict_push(input logic [31:0] a);
    exp_t e;
    bit   h;
    h = rv[a[11:2]] && (rt[a[11:2]] == a[31:12]);
    if (h) begin
      if (exp_hits < CMAX) exp_hits++;
      e.rdata = mem_word(a);
      e.err   = 1'b0;
      e.lat   = 3;
    end else begin
      if (exp_misses < CMAX) exp_misses++;
      if (mem_on) begin
        e.rdata = mem_word(a);
        e.err   = 1'b0;
        e.lat   = 5 + mem_wait;
        rv[a[11:2]] = 1'b1;
        rt[a[11:2]] = a[31:12];
      end else begin
        e.rdata = '0;
        e.err   = 1'b1;
        e.lat   = 3 + TMO;
      end
    end
    e.hits   = exp_hits[CW-1:0];
    e.misses = exp_misses[CW-1:0];
    e.acc    = cyc;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [31:0] a);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.cpu_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cpu_ready) begin
      check_val("ready_wait", 32'(bus.cpu_ready), 32'd1);
      return;
    end
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = a;
    predict_push(a);
    @(posedge clk);
    #1;
    bus.cpu_req = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check_val("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  // Response monitor
  int n_resp = 0, n_stw = 0, n_memreq = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (bus.st_write) n_stw++;
        if (bus.mem_req) n_memreq++;
        if (bus.cpu_valid) begin
          n_resp++;
          if (sb.size() == 0) begin
            check_val("unexpected_rsp", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check_val("rsp_rdata", bus.cpu_rdata, e.rdata);
            check_val("rsp_err", 32'(bus.cpu_err), 32'(e.err));
            check_val("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
            check_val("hit_count", 32'(hit_count), 32'(e.hits));
            check_val("miss_count", 32'(miss_count), 32'(e.misses));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, m, r, n;
    bus.cpu_req  = 1'b0;
    bus.cpu_addr = '0;
    repeat (3) @(negedge clk);
    check_val("rst_cpu_ready", 32'(bus.cpu_ready), 32'd1);
    check_val("rst_cpu_valid", 32'(bus.cpu_valid), 32'd0);
    check_val("rst_cpu_err", 32'(bus.cpu_err), 32'd0);
    check_val("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
    check_val("rst_st_read", 32'(bus.st_read), 32'd0);
    check_val("rst_st_write", 32'(bus.st_write), 32'd0);
    check_val("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check_val("rst_st_address", bus.st_address, 32'd0);
    check_val("rst_fill", bus.st_write_block, 32'd0);
    check_val("rst_hits", 32'(hit_count), 32'd0);
    check_val("rst_misses", 32'(miss_count), 32'd0);
    reset_n = 1'b1;

    // cold miss with two ack-wait cycles
    mem_wait = 2;
    s = n_stw;
    issue(32'h0000_0010);
    wait_drain();
    check_val("cold_st_write_cnt", 32'(n_stw - s), 32'd1);

    // refetch hits without touching memory
    mem_wait = 0;
    m = n_memreq;
    issue(32'h0000_0010);
    wait_drain();
    check_val("hit_no_mem_req", 32'(n_memreq - m), 32'd0);

    // conflict on the same index, then back-to-back refetch of the evicted line
    issue(32'h0000_1010);
    issue(32'h0000_0010);
    wait_drain();

    // memory timeout, then the same address still misses
    mem_on = 1'b0;
    issue(32'h0000_0020);
    wait_drain();
    mem_on = 1'b1;
    issue(32'h0000_0020);
    wait_drain();

    // request held high across a miss is serviced once
    r = n_resp;
    @(negedge clk);
    check_val("held_ready", 32'(bus.cpu_ready), 32'd1);
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 32'h0000_0030;
    predict_push(32'h0000_0030);
    repeat (4) @(negedge clk);
    bus.cpu_req = 1'b0;
    wait_drain();
    repeat (10) @(negedge clk);
    check_val("held_one_rsp", 32'(n_resp - r), 32'd1);

    // reset during MEM drops the fetch immediately
    mem_on = 1'b0;
    issue(32'h0000_0040);
    n = 0;
    while (!bus.mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_val("mem_req_seen", 32'(bus.mem_req), 32'd1);
    reset_n = 1'b0;
    #1;
    check_val("rstmid_mem_req", 32'(bus.mem_req), 32'd0);
    check_val("rstmid_ready", 32'(bus.cpu_ready), 32'd1);
    check_val("rstmid_valid", 32'(bus.cpu_valid), 32'd0);
    check_val("rstmid_hits", 32'(hit_count), 32'd0);
    check_val("rstmid_misses", 32'(miss_count), 32'd0);
    sb.delete();
    for (int i = 0; i < 1024; i++) rv[i] = 1'b0;
    exp_hits   = 0;
    exp_misses = 0;
    mem_on     = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;

    // hit counter saturation: 2^CW+3 hits
    issue(32'h0000_0050);
    for (int k = 0; k < (1 << CW) + 3; k++) issue(32'h0000_0050);
    wait_drain();
    check_val("hit_saturated", 32'(hit_count), 32'(CMAX));
    check_val("miss_after_sat", 32'(miss_count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
